// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback
//   MEM/WB pipeline register and the writer side of the register file's write
//   port. The retiring instruction is captured from MEM. Load data is extracted
//   and extended before the register, so WB only has to drive
//   WriteReg/WriteData/RegWrite for one full cycle. The register file commits
//   these values on the negedge of that same cycle. The block also flags
//   misaligned loads and counts retired instructions.
//
// Ports
//   Clk, Rst_n     clock (posedge) and asynchronous active-low reset
//   Stall, Flush   hold the register / load a bubble (Flush wins)
//   Mem*           retiring instruction fields from the MEM stage
//   WriteReg       register-file write address
//   WriteData      register-file write data
//   RegWrite       register-file write enable
//   WbValid        WB holds a real instruction
//   AlignErr       misaligned load in WB; its write is suppressed
//   RetireCount    instructions retired since reset (wraps)
module mem_wb_writeback #(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             MemValid,
    input  logic             MemRegWrite,
    input  logic [1:0]       MemToReg,
    input  logic [2:0]       MemLoadType,
    input  logic [1:0]       MemAddrLo,
    input  logic [31:0]      MemAluResult,
    input  logic [31:0]      MemLoadData,
    input  logic [31:0]      MemPcPlus8,
    input  logic [4:0]       MemDestReg,
    output logic [4:0]       WriteReg,
    output logic [31:0]      WriteData,
    output logic             RegWrite,
    output logic             WbValid,
    output logic             AlignErr,
    output logic [CNT_W-1:0] RetireCount
);

    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_LINK = 2'b10;

    logic             valid_q,     valid_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       dest_q,      dest_d;
    logic [31:0]      data_q,      data_d;
    logic             align_q,     align_d;
    logic [CNT_W-1:0] count_q,     count_d;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;
    logic        load_misaligned;
    logic [31:0] wb_value;

    // Load extraction, extension and the alignment check for the instruction
    // currently in MEM. Load types outside the defined set behave as lw.
    always_comb begin
        load_byte       = MemLoadData[{MemAddrLo, 3'b000} +: 8];
        load_half       = MemAddrLo[1] ? MemLoadData[31:16] : MemLoadData[15:0];
        load_value      = MemLoadData;
        load_misaligned = |MemAddrLo;
        case (MemLoadType)
            LT_LH: begin
                load_value      = {{16{load_half[15]}}, load_half};
                load_misaligned = MemAddrLo[0];
            end
            LT_LHU: begin
                load_value      = {16'h0000, load_half};
                load_misaligned = MemAddrLo[0];
            end
            LT_LB: begin
                load_value      = {{24{load_byte[7]}}, load_byte};
                load_misaligned = 1'b0;
            end
            LT_LBU: begin
                load_value      = {24'h000000, load_byte};
                load_misaligned = 1'b0;
            end
            default: begin
                load_value      = MemLoadData;
                load_misaligned = |MemAddrLo;
            end
        endcase
    end

    // Writeback source select; 00 and 11 both pick the ALU result.
    always_comb begin
        case (MemToReg)
            SRC_LOAD: wb_value = load_value;
            SRC_LINK: wb_value = MemPcPlus8;
            default:  wb_value = MemAluResult;
        endcase
    end

    // Next-state for the pipeline register. A flush only clears valid; the
    // other fields are don't-care because every output that matters is
    // gated by valid. The counter sees the occupant that is leaving, and a
    // stall freezes it even when a flush overrides the register itself.
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        dest_d      = dest_q;
        data_d      = data_q;
        align_d     = align_q;
        if (Flush) begin
            valid_d = 1'b0;
        end else if (!Stall) begin
            valid_d     = MemValid;
            reg_write_d = MemRegWrite;
            dest_d      = MemDestReg;
            data_d      = wb_value;
            align_d     = (MemToReg == SRC_LOAD) && load_misaligned;
        end

        count_d = count_q;
        if (valid_q && !Stall) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            dest_q      <= 5'd0;
            data_q      <= 32'd0;
            align_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            dest_q      <= dest_d;
            data_q      <= data_d;
            align_q     <= align_d;
            count_q     <= count_d;
        end
    end

    // $zero is never written, and a misaligned load never writes.
    always_comb begin
        WbValid     = valid_q;
        AlignErr    = valid_q & align_q;
        RegWrite    = valid_q & reg_write_q & (dest_q != 5'd0) & ~(valid_q & align_q);
        WriteReg    = dest_q;
        WriteData   = data_q;
        RetireCount = count_q;
    end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback
//   Directed and random stimulus for mem_wb_writeback with a narrow retire
//   counter so that wrap-around is reached quickly. A behavioural model of the
//   WB stage is kept alongside and compared after every clock edge.
module tb_mem_wb_writeback;

    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          Stall, Flush, MemValid, MemRegWrite;
    logic [1:0]    MemToReg;
    logic [2:0]    MemLoadType;
    logic [1:0]    MemAddrLo;
    logic [31:0]   MemAluResult, MemLoadData, MemPcPlus8;
    logic [4:0]    MemDestReg;
    logic [4:0]    WriteReg;
    logic [31:0]   WriteData;
    logic          RegWrite, WbValid, AlignErr;
    logic [CW-1:0] RetireCount;

    int n_asserts = 0;
    int n_fail    = 0;

    // Behavioural model of what WB currently holds.
    bit          m_valid;
    bit          m_rw;
    int          m_dest;
    logic [31:0] m_data;
    bit          m_err;
    int          m_cnt;

    mem_wb_writeback #(.CNT_W(CW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush),
        .MemValid(MemValid), .MemRegWrite(MemRegWrite), .MemToReg(MemToReg),
        .MemLoadType(MemLoadType), .MemAddrLo(MemAddrLo),
        .MemAluResult(MemAluResult), .MemLoadData(MemLoadData),
        .MemPcPlus8(MemPcPlus8), .MemDestReg(MemDestReg),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .WbValid(WbValid), .AlignErr(AlignErr), .RetireCount(RetireCount)
    );

    always #5 Clk = ~Clk;

    // Value a load returns, computed with plain integer arithmetic.
    function automatic logic [31:0] loadResult(input int ltype, input int a, input logic [31:0] ld);
        longint w;
        longint v;
        w = longint'(ld);
        case (ltype)
            1, 2: begin
                v = (w / ((a >= 2) ? 65536 : 1)) % 65536;
                if (ltype == 1 && v >= 32768) v = v - 65536;
            end
            3, 4: begin
                v = (w / (longint'(1) << (8 * a))) % 256;
                if (ltype == 3 && v >= 128) v = v - 256;
            end
            default: v = w;
        endcase
        return v[31:0];
    endfunction

    function automatic bit misaligned(input int ltype, input int a);
        if (ltype == 3 || ltype == 4) return 1'b0;
        if (ltype == 1 || ltype == 2) return (a % 2) == 1;
        return a != 0;
    endfunction

    task automatic modelReset();
        m_valid = 0; m_rw = 0; m_dest = 0; m_data = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic modelClock();
        if (m_valid && !Stall) m_cnt = (m_cnt + 1) % (1 << CW);
        if (Flush) begin
            m_valid = 0;
        end else if (!Stall) begin
            m_valid = MemValid;
            m_rw    = MemRegWrite;
            m_dest  = int'(MemDestReg);
            case (MemToReg)
                2'd1:    m_data = loadResult(int'(MemLoadType), int'(MemAddrLo), MemLoadData);
                2'd2:    m_data = MemPcPlus8;
                default: m_data = MemAluResult;
            endcase
            m_err = (MemToReg == 2'd1) && misaligned(int'(MemLoadType), int'(MemAddrLo));
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        bit e_align;
        bit e_we;
        e_align = m_valid && m_err;
        e_we    = m_valid && m_rw && (m_dest != 0) && !e_align;
        checkVal({tag, ".WbValid"},     32'(WbValid),     32'(m_valid));
        checkVal({tag, ".AlignErr"},    32'(AlignErr),    32'(e_align));
        checkVal({tag, ".RegWrite"},    32'(RegWrite),    32'(e_we));
        checkVal({tag, ".RetireCount"}, 32'(RetireCount), 32'(m_cnt));
        if (m_valid) begin
            checkVal({tag, ".WriteReg"},  32'(WriteReg), 32'(m_dest));
            checkVal({tag, ".WriteData"}, WriteData,     m_data);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rw, input logic [1:0] src,
                                 input logic [2:0] lt, input logic [1:0] a,
                                 input logic [31:0] alu, input logic [31:0] ld,
                                 input logic [31:0] pc, input logic [4:0] d,
                                 input logic st, input logic fl);
        MemValid = v; MemRegWrite = rw; MemToReg = src; MemLoadType = lt;
        MemAddrLo = a; MemAluResult = alu; MemLoadData = ld; MemPcPlus8 = pc;
        MemDestReg = d; Stall = st; Flush = fl;
    endtask

    task automatic cycle(input string tag);
        @(posedge Clk);
        modelClock();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        Rst_n = 1'b0;
        applyStimulus(0, 0, 2'd0, 3'd0, 2'd0, 0, 0, 0, 5'd0, 0, 0);
        modelReset();
        #3;
        checkOutput("reset");
        #4 Rst_n = 1'b1;

        // ALU write
        applyStimulus(1, 1, 2'b00, 3'd0, 2'd0, 32'h1234, 0, 0, 5'd8, 0, 0);
        cycle("alu");
        checkVal("alu.RegWrite", 32'(RegWrite), 32'd1);
        checkVal("alu.WriteReg", 32'(WriteReg), 32'd8);
        checkVal("alu.WriteData", WriteData, 32'h1234);

        // Load extraction
        applyStimulus(1, 1, 2'b01, 3'b011, 2'd3, 0, 32'h80FF7F01, 0, 5'd9, 0, 0);
        cycle("lb");
        checkVal("lb.WriteData", WriteData, 32'hFFFFFF80);
        applyStimulus(1, 1, 2'b01, 3'b100, 2'd3, 0, 32'h80FF7F01, 0, 5'd9, 0, 0);
        cycle("lbu");
        checkVal("lbu.WriteData", WriteData, 32'h00000080);
        applyStimulus(1, 1, 2'b01, 3'b001, 2'd2, 0, 32'h80FF7F01, 0, 5'd9, 0, 0);
        cycle("lh");
        checkVal("lh.WriteData", WriteData, 32'hFFFF80FF);
        applyStimulus(1, 1, 2'b10, 3'd0, 2'd0, 32'h5, 0, 32'hABCD0008, 5'd31, 0, 0);
        cycle("link");
        checkVal("link.WriteData", WriteData, 32'hABCD0008);

        // Destination $zero
        applyStimulus(1, 1, 2'b00, 3'd0, 2'd0, 32'h77, 0, 0, 5'd0, 0, 0);
        cycle("zero");
        checkVal("zero.RegWrite", 32'(RegWrite), 32'd0);
        checkVal("zero.WbValid", 32'(WbValid), 32'd1);

        // Misalignment
        applyStimulus(1, 1, 2'b01, 3'b000, 2'd2, 0, 32'h11223344, 0, 5'd4, 0, 0);
        cycle("lw_mis");
        checkVal("lw_mis.AlignErr", 32'(AlignErr), 32'd1);
        checkVal("lw_mis.RegWrite", 32'(RegWrite), 32'd0);
        applyStimulus(1, 1, 2'b01, 3'b001, 2'd1, 0, 32'h11223344, 0, 5'd4, 0, 0);
        cycle("lh_mis");
        checkVal("lh_mis.AlignErr", 32'(AlignErr), 32'd1);
        applyStimulus(1, 1, 2'b01, 3'b011, 2'd1, 0, 32'h11223344, 0, 5'd4, 0, 0);
        cycle("lb_ok");
        checkVal("lb_ok.AlignErr", 32'(AlignErr), 32'd0);
        checkVal("lb_ok.WriteData", WriteData, 32'h00000033);
        applyStimulus(1, 1, 2'b00, 3'b000, 2'd2, 32'h99, 0, 0, 5'd4, 0, 0);
        cycle("alu_addr2");
        checkVal("alu_addr2.AlignErr", 32'(AlignErr), 32'd0);

        // Stall, then Flush with Stall, then Flush alone
        applyStimulus(1, 1, 2'b00, 3'd0, 2'd0, 32'hCAFE, 0, 0, 5'd5, 0, 0);
        cycle("pre_stall");
        applyStimulus(1, 1, 2'b00, 3'd0, 2'd0, 32'hDEAD, 0, 0, 5'd6, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            checkVal("stall.WriteData", WriteData, 32'hCAFE);
        end
        applyStimulus(1, 1, 2'b00, 3'd0, 2'd0, 32'hDEAD, 0, 0, 5'd6, 1, 1);
        cycle("stall_flush");
        checkVal("stall_flush.WbValid", 32'(WbValid), 32'd0);
        applyStimulus(1, 1, 2'b00, 3'd0, 2'd0, 32'hBEEF, 0, 0, 5'd7, 0, 0);
        cycle("refill");
        applyStimulus(1, 1, 2'b00, 3'd0, 2'd0, 32'hBEEF, 0, 0, 5'd7, 0, 1);
        cycle("flush");

        // Run the counter through its wrap point
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1, 2'b00, 3'd0, 2'd0, 32'(i), 0, 0, 5'(i + 1), 0, 0);
            cycle("wrap");
        end

        // Asynchronous reset in the middle of a writing cycle
        applyStimulus(1, 1, 2'b00, 3'd0, 2'd0, 32'h4242, 0, 0, 5'd3, 0, 0);
        cycle("pre_reset");
        #2 Rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset");
        checkVal("async_reset.WriteData", WriteData, 32'd0);
        #3 Rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                          2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                          2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                          5'($urandom_range(0, 31)), $urandom_range(0, 4) == 0,
                          $urandom_range(0, 6) == 0);
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
